// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared constants for the I2C/host RAM arbiter: grant-state
//               encoding and the default RAM depth (log2).
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int c_ld_nbytes_default = 3;

    localparam int c_gnt_w = 2;

    localparam logic [c_gnt_w-1:0] GNT_IDLE  = 2'd0;
    localparam logic [c_gnt_w-1:0] GNT_I2CWR = 2'd1;
    localparam logic [c_gnt_w-1:0] GNT_PF    = 2'd2;
    localparam logic [c_gnt_w-1:0] GNT_HOST  = 2'd3;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_ram_sp.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_sp
// Description : Single-port synchronous byte RAM with registered read data.
//               Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ram_sp
    import i2c_arb_pkg::*;
#(
    parameter int AW = c_ld_nbytes_default
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdat,
    output logic [7:0]    rdat
);

    logic [7:0] r_mem [2**AW];

    // Read-before-write: rdat on a write cycle returns the old byte.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdat;
        end
        rdat <= r_mem[addr];
    end

endmodule : i2c_ram_sp
`default_nettype wire

// File: rtl/i2c_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_ram_arbiter
// Description : Shares one byte RAM between an I2C slave (register-pointer
//               semantics, prefetched read byte) and a host req/ack port.
//               Optional macro I2CARB_WPROT_EN discards I2C writes at or
//               above WP_BASE.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_ram_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int LD_NBYTES = c_ld_nbytes_default,
    parameter int WP_BASE   = 2**LD_NBYTES - 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i2c_as,
    input  logic                 i2c_rs,
    input  logic                 i2c_ws,
    input  logic [7:0]           i2c_wdat,
    output logic [7:0]           i2c_rdat,
    output logic [LD_NBYTES-1:0] i2c_idx,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [LD_NBYTES-1:0] host_addr,
    input  logic [7:0]           host_wdat,
    output logic                 host_ack,
    output logic [7:0]           host_rdat
);

`ifdef I2CARB_WPROT_EN
    localparam bit c_wprot_en = 1'b1;
`else
    localparam bit c_wprot_en = 1'b0;
`endif

    localparam logic [LD_NBYTES:0] c_wp_base = (LD_NBYTES+1)'(WP_BASE);

    // Grant state: r_gnt is the RAM operation issued this cycle, r_last the
    // one issued last cycle whose read data is now on the RAM output.
    logic [c_gnt_w-1:0]   r_gnt;
    logic [c_gnt_w-1:0]   w_gnt_nxt;
    logic [c_gnt_w-1:0]   r_last;
    logic                 r_last_rd;

    logic [LD_NBYTES-1:0] r_idx;
    logic                 r_as_seen;
    logic                 r_wr_pend;
    logic                 r_pf_pend;
    logic [LD_NBYTES-1:0] r_wr_addr;
    logic [7:0]           r_wr_data;

    logic [7:0]           r_i2c_rdat;
    logic                 r_host_ack;
    logic [7:0]           r_host_rdat;

    logic                 w_ws_ptr;
    logic                 w_ws_data;
    logic                 w_host_hit;
    logic                 w_pf_set;
    logic                 w_wr_pend_n;
    logic                 w_pf_pend_n;
    logic                 w_host_busy;
    logic                 w_wp_hit;

    logic                 w_ram_we;
    logic [LD_NBYTES-1:0] w_ram_addr;
    logic [7:0]           w_ram_wdat;
    logic [7:0]           w_ram_rdat;

    // ------------------------------------------------------------------
    // Strobe decode: rs beats ws; a concurrent as never survives rs/ws.
    // ------------------------------------------------------------------
    always_comb begin
        w_ws_ptr   = i2c_ws && !i2c_rs && r_as_seen;
        w_ws_data  = i2c_ws && !i2c_rs && !r_as_seen;
        w_host_hit = (r_gnt == GNT_HOST) && host_we && (host_addr == r_idx);
        w_pf_set   = i2c_rs || i2c_ws || w_host_hit;
        w_wp_hit   = c_wprot_en && ({1'b0, r_wr_addr} >= c_wp_base);
    end

    // Pending flags after this edge: a set wins over the clear that comes
    // from the flag's own grant executing this cycle.
    always_comb begin
        w_wr_pend_n = w_ws_data || (r_wr_pend && (r_gnt != GNT_I2CWR));
        w_pf_pend_n = w_pf_set  || (r_pf_pend && (r_gnt != GNT_PF));
        w_host_busy = (r_gnt == GNT_HOST) || (r_last == GNT_HOST) || r_host_ack;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx     <= '0;
            r_as_seen <= 1'b0;
            r_wr_pend <= 1'b0;
            r_pf_pend <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_pend <= w_wr_pend_n;
            r_pf_pend <= w_pf_pend_n;

            if (i2c_rs || i2c_ws) begin
                r_as_seen <= 1'b0;
            end else if (i2c_as) begin
                r_as_seen <= 1'b1;
            end

            if (i2c_rs) begin
                r_idx <= r_idx + 1'b1;
            end else if (w_ws_ptr) begin
                r_idx <= i2c_wdat[LD_NBYTES-1:0];
            end else if (w_ws_data) begin
                r_idx <= r_idx + 1'b1;
            end

            if (w_ws_data) begin
                r_wr_addr <= r_idx;
                r_wr_data <= i2c_wdat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM: state register / next state / RAM port outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_gnt <= GNT_IDLE;
        end else begin
            r_gnt <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_gnt_nxt = GNT_IDLE;
        if (w_wr_pend_n) begin
            w_gnt_nxt = GNT_I2CWR;
        end else if (w_pf_pend_n) begin
            w_gnt_nxt = GNT_PF;
        end else if (host_req && !w_host_busy) begin
            w_gnt_nxt = GNT_HOST;
        end
    end

    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = host_addr;
        w_ram_wdat = host_wdat;
        case (r_gnt)
            GNT_I2CWR: begin
                w_ram_we   = !w_wp_hit;
                w_ram_addr = r_wr_addr;
                w_ram_wdat = r_wr_data;
            end
            GNT_PF: begin
                w_ram_addr = r_idx;
            end
            GNT_HOST: begin
                w_ram_we   = host_we;
            end
            default: begin
                w_ram_we   = 1'b0;
            end
        endcase
    end

    i2c_ram_sp #(
        .AW   (LD_NBYTES)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .wdat (w_ram_wdat),
        .rdat (w_ram_rdat)
    );

    // ------------------------------------------------------------------
    // Result capture: one cycle after a grant the RAM output is valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_last      <= GNT_IDLE;
            r_last_rd   <= 1'b0;
            r_i2c_rdat  <= '0;
            r_host_ack  <= 1'b0;
            r_host_rdat <= '0;
        end else begin
            r_last     <= r_gnt;
            r_last_rd  <= (r_gnt == GNT_HOST) && !host_we;
            r_host_ack <= (r_last == GNT_HOST);
            if (r_last == GNT_PF) begin
                r_i2c_rdat <= w_ram_rdat;
            end
            if ((r_last == GNT_HOST) && r_last_rd) begin
                r_host_rdat <= w_ram_rdat;
            end
        end
    end

    assign i2c_rdat  = r_i2c_rdat;
    assign i2c_idx   = r_idx;
    assign host_ack  = r_host_ack;
    assign host_rdat = r_host_rdat;

endmodule : i2c_ram_arbiter
`default_nettype wire

// File: tb/tb_i2c_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_ram_arbiter
// Description : Directed self-checking bench for i2c_ram_arbiter (LD_NBYTES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_ram_arbiter;

    logic       clk;
    logic       aresetn;
    logic       i2c_as;
    logic       i2c_rs;
    logic       i2c_ws;
    logic [7:0] i2c_wdat;
    logic [7:0] i2c_rdat;
    logic [2:0] i2c_idx;
    logic       host_req;
    logic       host_we;
    logic [2:0] host_addr;
    logic [7:0] host_wdat;
    logic       host_ack;
    logic [7:0] host_rdat;

    int n_vec;
    int n_err;

    i2c_ram_arbiter #(
        .LD_NBYTES (3),
        .WP_BASE   (6)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .i2c_as    (i2c_as),
        .i2c_rs    (i2c_rs),
        .i2c_ws    (i2c_ws),
        .i2c_wdat  (i2c_wdat),
        .i2c_rdat  (i2c_rdat),
        .i2c_idx   (i2c_idx),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdat (host_wdat),
        .host_ack  (host_ack),
        .host_rdat (host_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle strobe, then three quiet cycles so i2c_rdat has settled.
    task automatic strb(input logic as_, input logic rs_, input logic ws_, input logic [7:0] d);
        i2c_as = as_; i2c_rs = rs_; i2c_ws = ws_; i2c_wdat = d;
        tick();
        i2c_as = 1'b0; i2c_rs = 1'b0; i2c_ws = 1'b0;
        idle(3);
    endtask

    // Counts edges after the first sampling edge until host_ack is seen.
    task automatic wait_ack(input string tag, output int lat);
        lat = 0;
        tick();
        i2c_as = 1'b0; i2c_rs = 1'b0; i2c_ws = 1'b0;
        while (!host_ack && lat < 20) begin
            tick();
            lat++;
        end
        if (!host_ack) chk({tag, "_timeout"}, 32'd0, 32'd1);
        host_req = 1'b0;
    endtask

    task automatic host_xfer(input string tag, input logic we, input logic [2:0] a,
                             input logic [7:0] d, output logic [7:0] rd, output int lat);
        host_we = we; host_addr = a; host_wdat = d; host_req = 1'b1;
        wait_ack(tag, lat);
        rd = host_rdat;
        idle(2);
    endtask

    logic [7:0] pre [8];
    logic [7:0] rd;
    logic [7:0] exp6;
    int         lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0; n_err = 0;
        aresetn = 1'b0;
        i2c_as = 1'b0; i2c_rs = 1'b0; i2c_ws = 1'b0; i2c_wdat = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 3'd0; host_wdat = 8'h00;
        idle(3);
        chk("rst_i2c_rdat", i2c_rdat, 32'h00);
        chk("rst_i2c_idx", i2c_idx, 32'h0);
        chk("rst_host_ack", host_ack, 32'h0);
        chk("rst_host_rdat", host_rdat, 32'h00);
        aresetn = 1'b1;
        idle(3);

        pre = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h77};
        for (int i = 0; i < 8; i++) begin
            host_xfer("preload", 1'b1, 3'(i), pre[i], rd, lat);
            if (i == 0) chk("host_wr_latency", lat, 32'd2);
        end
        host_xfer("rd5", 1'b0, 3'd5, 8'h00, rd, lat);
        chk("host_rd_mem5", rd, 32'h55);
        chk("host_rd_latency", lat, 32'd2);

        // Pointer set; upper bits of the pointer byte are ignored.
        strb(1'b1, 1'b0, 1'b0, 8'h00);
        strb(1'b0, 1'b0, 1'b1, 8'hF5);
        chk("ptr_idx", i2c_idx, 32'd5);
        chk("ptr_rdat", i2c_rdat, 32'h55);
        host_xfer("ptr_nowr", 1'b0, 3'd0, 8'h00, rd, lat);
        chk("ptr_no_write_mem0", rd, 32'h10);

        // Write burst.
        strb(1'b1, 1'b0, 1'b0, 8'h00);
        strb(1'b0, 1'b0, 1'b1, 8'h02);
        strb(1'b0, 1'b0, 1'b1, 8'hA1);
        strb(1'b0, 1'b0, 1'b1, 8'hB2);
        chk("burst_idx", i2c_idx, 32'd4);
        chk("burst_rdat", i2c_rdat, 32'h00);
        host_xfer("burst_m2", 1'b0, 3'd2, 8'h00, rd, lat);
        chk("burst_mem2", rd, 32'hA1);
        host_xfer("burst_m3", 1'b0, 3'd3, 8'h00, rd, lat);
        chk("burst_mem3", rd, 32'hB2);

        // Read with pointer wrap 7 -> 0.
        strb(1'b1, 1'b0, 1'b0, 8'h00);
        strb(1'b0, 1'b0, 1'b1, 8'h07);
        chk("wrap_idx7", i2c_idx, 32'd7);
        chk("wrap_rdat7", i2c_rdat, 32'h77);
        strb(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap_idx0", i2c_idx, 32'd0);
        chk("wrap_rdat0", i2c_rdat, 32'h10);

        // rs and ws together: read advance only, write dropped.
        strb(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("rsws_idx", i2c_idx, 32'd1);
        host_xfer("rsws_m0", 1'b0, 3'd0, 8'h00, rd, lat);
        chk("rsws_mem0", rd, 32'h10);

        // Contention: data ws and host read of the same address together.
        strb(1'b1, 1'b0, 1'b0, 8'h00);
        strb(1'b0, 1'b0, 1'b1, 8'h03);
        chk("cont_pre_rdat", i2c_rdat, 32'hB2);
        i2c_ws = 1'b1; i2c_wdat = 8'hC3;
        host_we = 1'b0; host_addr = 3'd3; host_req = 1'b1;
        wait_ack("cont", lat);
        chk("cont_latency", lat, 32'd4);
        chk("cont_host_rdat", host_rdat, 32'hC3);
        idle(3);
        chk("cont_idx", i2c_idx, 32'd4);

        // Host write to the current pointer refreshes the prefetched byte.
        strb(1'b1, 1'b0, 1'b0, 8'h00);
        strb(1'b0, 1'b0, 1'b1, 8'h06);
        chk("coh_pre_rdat", i2c_rdat, 32'h00);
        host_xfer("coh_wr", 1'b1, 3'd6, 8'h5A, rd, lat);
        chk("coh_rdat", i2c_rdat, 32'h5A);

        // I2C data write into the write-protected region (when enabled).
`ifdef I2CARB_WPROT_EN
        exp6 = 8'h5A;
`else
        exp6 = 8'h99;
`endif
        strb(1'b0, 1'b0, 1'b1, 8'h99);
        chk("wp_idx", i2c_idx, 32'd7);
        chk("wp_rdat", i2c_rdat, 32'h77);
        host_xfer("wp_m6", 1'b0, 3'd6, 8'h00, rd, lat);
        chk("wp_mem6", rd, {24'h0, exp6});

        // Reset pulsed while a host read is in flight.
        host_we = 1'b0; host_addr = 3'd7; host_req = 1'b1;
        tick();
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_ack", host_ack, 32'h0);
            tick();
        end
        chk("midrst_idx", i2c_idx, 32'd0);
        chk("midrst_i2c_rdat", i2c_rdat, 32'h00);
        chk("midrst_host_rdat", host_rdat, 32'h00);
        aresetn = 1'b1;
        lat = 0;
        while (!host_ack && lat < 20) begin
            tick();
            lat++;
        end
        chk("midrst_fresh_ack", host_ack, 32'h1);
        chk("midrst_ram_kept", host_rdat, 32'h77);
        host_req = 1'b0;
        idle(3);
        chk("midrst_ack_dropped", host_ack, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_i2c_ram_arbiter
`default_nettype wire
